// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: PLL reset, lock qualification with bounded retries, and system reset release
module pll_reset_sequencer #(
  parameter int RESET_CYCLES        = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 1000000,
  parameter int MAX_RETRIES         = 4
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fault,
  output logic [7:0] lock_loss_cnt
);
  localparam int RW = RESET_CYCLES > 1 ? $clog2(RESET_CYCLES) : 1;
  localparam int SW = LOCK_STABLE_CYCLES > 1 ? $clog2(LOCK_STABLE_CYCLES) : 1;
  localparam int TW = LOCK_TIMEOUT_CYCLES > 1 ? $clog2(LOCK_TIMEOUT_CYCLES) : 1;
  localparam int YW = $clog2(MAX_RETRIES + 1);
  localparam logic [RW-1:0] RST_MAX = RW'(RESET_CYCLES - 1);
  localparam logic [SW-1:0] STB_MAX = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [YW-1:0] RETRY_LIM = YW'(MAX_RETRIES);
  localparam logic [2:0] S_RESET  = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_STABLE = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_FAULT  = 3'd4;
  logic          sync0, locked_s;
  logic [2:0]    state, nstate;
  logic [RW-1:0] rst_cnt;
  logic [SW-1:0] stb_cnt;
  logic [TW-1:0] to_cnt;
  logic [YW-1:0] retry_cnt, retry_nx;
  logic          rst_done, stb_done, to_done, attempt, fail;
  logic [2:0]    fail_st;
  assign rst_done = rst_cnt == RST_MAX;
  assign stb_done = stb_cnt == STB_MAX;
  assign to_done  = to_cnt == TO_MAX;
  assign retry_nx = retry_cnt + 1'b1;
  assign fail_st  = retry_nx == RETRY_LIM ? S_FAULT : S_RESET;
  assign attempt  = state == S_WAIT || state == S_STABLE;
  assign fail     = attempt && (nstate == S_RESET || nstate == S_FAULT);
  always_comb begin
    nstate = state;
    case (state)
      S_RESET:  nstate = rst_done ? S_WAIT : S_RESET;
      S_WAIT:   nstate = to_done ? fail_st : locked_s ? S_STABLE : S_WAIT;
      S_STABLE: nstate = (locked_s && stb_done) ? S_RUN : to_done ? fail_st : locked_s ? S_STABLE : S_WAIT;
      S_RUN:    nstate = locked_s ? S_RUN : S_RESET;
      default:  nstate = S_FAULT;
    endcase
  end
  always_ff @(posedge refclk) begin
    if (rst) begin
      sync0         <= 1'b0;
      locked_s      <= 1'b0;
      state         <= S_RESET;
      rst_cnt       <= '0;
      stb_cnt       <= '0;
      to_cnt        <= '0;
      retry_cnt     <= '0;
      lock_loss_cnt <= '0;
      pll_rst       <= 1'b1;
      sys_rst       <= 1'b1;
      ready         <= 1'b0;
      fault         <= 1'b0;
    end else begin
      sync0         <= pll_locked;
      locked_s      <= sync0;
      state         <= nstate;
      rst_cnt       <= (state == S_RESET && !rst_done) ? rst_cnt + 1'b1 : '0;
      to_cnt        <= attempt ? to_cnt + 1'b1 : '0;
      stb_cnt       <= (state == S_STABLE && locked_s) ? stb_cnt + 1'b1 : '0;
      retry_cnt     <= nstate == S_RUN ? '0 : fail ? retry_nx : retry_cnt;
      lock_loss_cnt <= (state == S_RUN && !locked_s && lock_loss_cnt != 8'hff) ? lock_loss_cnt + 1'b1 : lock_loss_cnt;
      pll_rst       <= nstate == S_RESET || nstate == S_FAULT;
      sys_rst       <= nstate != S_RUN;
      ready         <= nstate == S_RUN;
      fault         <= nstate == S_FAULT;
    end
  end
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: directed checks of bring-up, retries, fault, lock loss and saturation
module tb_pll_reset_sequencer;
  logic       refclk, rst, pll_locked;
  logic       pll_rst, sys_rst, ready, fault;
  logic [7:0] lock_loss_cnt;
  int         checks, errors;
  pll_reset_sequencer #(
    .RESET_CYCLES(4),
    .LOCK_STABLE_CYCLES(8),
    .LOCK_TIMEOUT_CYCLES(32),
    .MAX_RETRIES(3)
  ) dut (
    .refclk(refclk),
    .rst(rst),
    .pll_locked(pll_locked),
    .pll_rst(pll_rst),
    .sys_rst(sys_rst),
    .ready(ready),
    .fault(fault),
    .lock_loss_cnt(lock_loss_cnt)
  );
  initial refclk = 1'b0;
  always #5 refclk = ~refclk;
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(posedge refclk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic pulse_rst();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pll_rst"}, pll_rst, 1);
    chk({tag, "_sys_rst"}, sys_rst, 1);
    chk({tag, "_ready"}, ready, 0);
    chk({tag, "_fault"}, fault, 0);
    chk({tag, "_llc"}, lock_loss_cnt, 0);
  endtask
  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    pll_locked = 1'b1;
    tick(2);
    chk_reset_outputs("reset");
    rst = 1'b0;
    for (int e = 1; e <= 13; e++) begin
      tick(1);
      chk($sformatf("clean_pll_rst_e%0d", e), pll_rst, e < 4);
      chk($sformatf("clean_sys_rst_e%0d", e), sys_rst, e < 13);
      chk($sformatf("clean_ready_e%0d", e), ready, e >= 13);
      chk($sformatf("clean_fault_e%0d", e), fault, 0);
      chk($sformatf("clean_llc_e%0d", e), lock_loss_cnt, 0);
    end
    pll_locked = 1'b0;
    pulse_rst();
    tick(9);
    pll_locked = 1'b1;
    tick(4);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    for (int e = 15; e <= 24; e++) begin
      tick(1);
      chk($sformatf("chatter_sys_rst_e%0d", e), sys_rst, 1);
    end
    tick(1);
    chk("chatter_sys_rst_e25", sys_rst, 0);
    chk("chatter_ready_e25", ready, 1);
    pll_locked = 1'b0;
    pulse_rst();
    for (int e = 1; e <= 108; e++) begin
      tick(1);
      chk($sformatf("nolock_pll_rst_e%0d", e), pll_rst, (e % 36) < 4);
      chk($sformatf("nolock_sys_rst_e%0d", e), sys_rst, 1);
      chk($sformatf("nolock_fault_e%0d", e), fault, e >= 108);
    end
    tick(50);
    chk("fault_hold_fault", fault, 1);
    chk("fault_hold_pll_rst", pll_rst, 1);
    chk("fault_hold_sys_rst", sys_rst, 1);
    pulse_rst();
    chk_reset_outputs("fault_clear");
    tick(36);
    chk("retry_pll_rst_e36", pll_rst, 1);
    chk("retry_cnt_e36", dut.retry_cnt, 1);
    pll_locked = 1'b1;
    tick(12);
    chk("retry_ready_e48", ready, 0);
    tick(1);
    chk("retry_ready_e49", ready, 1);
    chk("retry_cnt_e49", dut.retry_cnt, 0);
    pll_locked = 1'b0;
    tick(1);
    chk("loss_ready_n", ready, 1);
    tick(1);
    chk("loss_ready_n1", ready, 1);
    chk("loss_llc_n1", lock_loss_cnt, 0);
    tick(1);
    chk("loss_ready_n2", ready, 0);
    chk("loss_sys_rst_n2", sys_rst, 1);
    chk("loss_pll_rst_n2", pll_rst, 1);
    chk("loss_llc_n2", lock_loss_cnt, 1);
    pll_locked = 1'b1;
    tick(12);
    chk("relock_ready_pre", ready, 0);
    tick(1);
    chk("relock_ready", ready, 1);
    chk("relock_sys_rst", sys_rst, 0);
    for (int i = 0; i < 254; i++) begin
      pll_locked = 1'b0;
      tick(1);
      pll_locked = 1'b1;
      tick(20);
    end
    chk("sat_llc_255", lock_loss_cnt, 255);
    chk("sat_ready", ready, 1);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    tick(20);
    chk("sat_llc_hold", lock_loss_cnt, 255);
    chk("sat_ready_hold", ready, 1);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    tick(8);
    chk("stable_sys_rst", sys_rst, 1);
    chk("stable_pll_rst", pll_rst, 0);
    chk("stable_llc", lock_loss_cnt, 255);
    rst = 1'b1;
    tick(1);
    chk_reset_outputs("midrun_rst");
    rst = 1'b0;
    tick(13);
    chk("final_ready", ready, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
